// File: rtl/rs_syndrome_serial.sv
// Symbol-serial RS syndrome calculator (Horner per root, held result register, valid/ready on both sides).
// Optional in_abort port under `RS_SYN_ABORT_EN; one cycle from last symbol to syn_valid.
module rs_syndrome_serial #(
   parameter int                    SYMBOL_WIDTH = 3,
   parameter int                    N            = 7,
   parameter int                    K            = 5,
   parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011,
   parameter int                    FCR          = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SYMBOL_WIDTH-1:0]        in_sym,
`ifdef RS_SYN_ABORT_EN
   input  logic                           in_abort,
`endif
   output logic                           syn_valid,
   input  logic                           syn_ready,
   output logic [(N-K)*SYMBOL_WIDTH-1:0]  syndromes,
   output logic                           err_flag
);
   localparam int NSYN = N - K;
   localparam int Q    = (1 << SYMBOL_WIDTH) - 1;
   localparam int CW   = (N > 1) ? $clog2(N) : 1;

   function automatic logic [SYMBOL_WIDTH-1:0] mul_x(input logic [SYMBOL_WIDTH-1:0] a);
      logic [SYMBOL_WIDTH:0] t;
      t = {a, 1'b0};
      if (t[SYMBOL_WIDTH]) t = t ^ PRIM_POLY;
      return t[SYMBOL_WIDTH-1:0];
   endfunction

   function automatic logic [SYMBOL_WIDTH-1:0] alpha_pow(input int e);
      logic [SYMBOL_WIDTH-1:0] r;
      r = SYMBOL_WIDTH'(1);
      for (int i = 0; i < Q; i++)
         if (i < e) r = mul_x(r);
      return r;
   endfunction

   // Second operand is always an elaboration constant, so this folds to an XOR network.
   function automatic logic [SYMBOL_WIDTH-1:0] gf_mul(input logic [SYMBOL_WIDTH-1:0] a,
                                                      input logic [SYMBOL_WIDTH-1:0] b);
      logic [SYMBOL_WIDTH-1:0] p, aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < SYMBOL_WIDTH; i++) begin
         if (b[i]) p = p ^ aa;
         aa = mul_x(aa);
      end
      return p;
   endfunction

   logic [CW-1:0]               sym_cnt;
   logic [SYMBOL_WIDTH-1:0]     acc      [NSYN];
   logic [SYMBOL_WIDTH-1:0]     acc_next [NSYN];
   logic [NSYN*SYMBOL_WIDTH-1:0] syn_flat;
   logic                        last_pos, xfer, abort;

`ifdef RS_SYN_ABORT_EN
   assign abort = in_abort;
`else
   assign abort = 1'b0;
`endif

   assign last_pos = (sym_cnt == CW'(N - 1));
   // Only the word-completing symbol can overwrite an unaccepted result, so only it stalls.
   assign in_ready = !(syn_valid && !syn_ready && last_pos);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      syn_flat = '0;
      for (int j = 0; j < NSYN; j++) begin
         acc_next[j] = ((sym_cnt == '0) ? '0 : gf_mul(acc[j], alpha_pow((FCR + j) % Q))) ^ in_sym;
         syn_flat[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] = acc_next[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_cnt   <= '0;
         syndromes <= '0;
         err_flag  <= 1'b0;
         syn_valid <= 1'b0;
         for (int j = 0; j < NSYN; j++) acc[j] <= '0;
      end else begin
         if (syn_valid && syn_ready) syn_valid <= 1'b0;
         if (abort) begin
            sym_cnt <= '0;
         end else if (xfer) begin
            for (int j = 0; j < NSYN; j++) acc[j] <= acc_next[j];
            if (last_pos) begin
               sym_cnt   <= '0;
               syndromes <= syn_flat;
               err_flag  <= |syn_flat;
               syn_valid <= 1'b1;
            end else begin
               sym_cnt <= sym_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rs_syndrome_serial.sv
// Bench for rs_syndrome_serial at default parameters: directed table, backpressure, reset/abort, random words.
module tb_rs_syndrome_serial;
   localparam int W = 3, N = 7, K = 5, NS = 2, Q = 7, FCR = 1;
   typedef logic [N*W-1:0] word_t;   // word[i*W +: W] = coefficient of x^i
   typedef struct {
      word_t          word;
      logic [NS*W-1:0] syn;
      logic           err;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, syn_ready = 1'b1;
   logic in_ready, syn_valid, err_flag;
   logic [W-1:0]    in_sym = '0;
   logic [NS*W-1:0] syndromes;
`ifdef RS_SYN_ABORT_EN
   logic in_abort = 1'b0;
`endif

   rs_syndrome_serial dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
`ifdef RS_SYN_ABORT_EN
      .in_abort(in_abort),
`endif
      .syn_valid(syn_valid), .syn_ready(syn_ready), .syndromes(syndromes), .err_flag(err_flag));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [NS*W:0] exp_q[$];
   logic [NS*W:0] mon_e;
   logic [W-1:0]  gexp[Q];
   int            glog[1<<W];
   bit            rnd_ready = 1'b0;
   vec_t          tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
      if (a == 0 || b == 0) return '0;
      return gexp[(glog[a] + glog[b]) % Q];
   endfunction

   // Direct evaluation S_j = sum_i r_i * alpha^((FCR+j)*i), returns {err, syndromes}.
   function automatic logic [NS*W:0] model(input word_t w);
      logic [NS*W-1:0] s;
      s = '0;
      for (int j = 0; j < NS; j++)
         for (int i = 0; i < N; i++)
            s[j*W +: W] = s[j*W +: W] ^ gmul(w[i*W +: W], gexp[((FCR + j) * i) % Q]);
      return {|s, s};
   endfunction

   // Non-systematic codeword m(x)*g(x), g(x) = prod (x + alpha^(FCR+j)).
   function automatic word_t encode(input logic [K*W-1:0] m);
      logic [W-1:0] g[NS+1];
      logic [W-1:0] ng[NS+1];
      word_t        c;
      for (int d = 0; d <= NS; d++) g[d] = (d == 0) ? W'(1) : '0;
      for (int j = 0; j < NS; j++) begin
         for (int d = 0; d <= NS; d++)
            ng[d] = ((d > 0) ? g[d-1] : '0) ^ gmul(g[d], gexp[(FCR + j) % Q]);
         g = ng;
      end
      c = '0;
      for (int a = 0; a < K; a++)
         for (int b = 0; b <= NS; b++)
            c[(a+b)*W +: W] = c[(a+b)*W +: W] ^ gmul(m[a*W +: W], g[b]);
      return c;
   endfunction

   // Every handshake consumes the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && syn_valid && syn_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none", syndromes);
         end else begin
            mon_e = exp_q.pop_front();
            chk("hs_syndromes", 32'(syndromes), 32'(mon_e[NS*W-1:0]));
            chk("hs_err_flag", 32'(err_flag), 32'(mon_e[NS*W]));
         end
      end
   end

   always @(posedge clk) if (rnd_ready) #1 syn_ready = ($urandom_range(3) != 0);

   // Caller and task both sit at posedge+1; returns just after the transfer edge.
   task automatic send_sym(input logic [W-1:0] s);
      int t;
      in_valid = 1'b1;
      in_sym   = s;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout actual=0 required=1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_word(input word_t w, input int gap_pct, input int nsyms);
      for (int i = N - 1; i >= N - nsyms; i--) begin
         if ($urandom_range(99) < gap_pct) idle($urandom_range(3, 1));
         send_sym(w[i*W +: W]);
      end
   endtask

   initial begin
      logic [W:0] e;
      word_t      w;
      int         t;
      e = 1;
      for (int k = 0; k < Q; k++) begin
         gexp[k] = e[W-1:0];
         glog[e[W-1:0]] = k;
         e = e << 1;
         if (e[W]) e = e ^ 4'b1011;
      end
      tbl[0] = '{21'd0,                          6'b000_000, 1'b0};
      tbl[1] = '{21'b000_000_000_000_000_000_001, 6'b001_001, 1'b1};
      tbl[2] = '{21'b001_000_000_000_000_000_000, 6'b111_101, 1'b1};
      tbl[3] = '{{7{3'b001}},                    6'b000_000, 1'b0};
      tbl[4] = '{21'b000_000_000_000_000_001_000, 6'b100_010, 1'b1};

      @(negedge clk);
      chk("rst_syn_valid", 32'(syn_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_syndromes", 32'(syndromes), 0);
      chk("rst_err_flag", 32'(err_flag), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed table, checking the one-cycle latency on the last symbol.
      for (int v = 0; v < 5; v++) begin
         exp_q.push_back({tbl[v].err, tbl[v].syn});
         send_word(tbl[v].word, 0, N - 1);
         chk("pre_last_valid", 32'(syn_valid), 0);
         send_sym(tbl[v].word[W-1:0]);
         chk("lat_syn_valid", 32'(syn_valid), 1);
         chk("tbl_syndromes", 32'(syndromes), 32'(tbl[v].syn));
         chk("tbl_err_flag", 32'(err_flag), 32'(tbl[v].err));
         idle(2);
      end

      // Backpressure: word 2's last symbol stalls until word 1 is taken.
      syn_ready = 1'b0;
      exp_q.push_back({tbl[1].err, tbl[1].syn});
      exp_q.push_back({tbl[2].err, tbl[2].syn});
      send_word(tbl[1].word, 0, N);
      send_word(tbl[2].word, 0, N - 1);
      in_valid = 1'b1;
      in_sym   = tbl[2].word[W-1:0];
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_syn_valid", 32'(syn_valid), 1);
         chk("bp_syndromes_held", 32'(syndromes), 32'(tbl[1].syn));
      end
      @(posedge clk);
      #1 syn_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("b2b_syn_valid", 32'(syn_valid), 1);
      chk("b2b_syndromes", 32'(syndromes), 32'(tbl[2].syn));
      idle(2);

      // Reset mid-codeword discards the partial word and clears the held outputs.
      send_word(tbl[0].word, 0, 3);
      rst_n = 1'b0;
      #1;
      chk("midrst_syndromes", 32'(syndromes), 0);
      chk("midrst_err_flag", 32'(err_flag), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back({tbl[2].err, tbl[2].syn});
      send_word(tbl[2].word, 0, N);
      chk("postrst_syndromes", 32'(syndromes), 32'(tbl[2].syn));
      idle(2);

`ifdef RS_SYN_ABORT_EN
      send_word(tbl[3].word, 0, 3);
      in_abort = 1'b1;
      idle(1);
      in_abort = 1'b0;
      exp_q.push_back({tbl[2].err, tbl[2].syn});
      send_word(tbl[2].word, 0, N);
      chk("abort3_syndromes", 32'(syndromes), 32'(tbl[2].syn));
      idle(2);
      send_word(tbl[1].word, 0, N - 1);
      in_abort = 1'b1;
      send_sym(tbl[1].word[W-1:0]);
      in_abort = 1'b0;
      chk("abort7_syn_valid", 32'(syn_valid), 0);
      idle(3);
      chk("abort7_still_idle", 32'(syn_valid), 0);
      exp_q.push_back({tbl[4].err, tbl[4].syn});
      send_word(tbl[4].word, 0, N);
      idle(2);
`endif

      // Random codewords with gaps and random downstream stalls.
      rnd_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         if (n % 2 == 0) w = encode(K*W'($urandom));
         else            w = word_t'($urandom);
         if (n % 2 == 0) chk("enc_model_zero", 32'(model(w)), 0);
         exp_q.push_back(model(w));
         send_word(w, 30, N);
      end
      rnd_ready = 1'b0;
      @(posedge clk);
      #2 syn_ready = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         t++;
         @(posedge clk);
      end
      #1;
      chk("drain_pending", 32'(exp_q.size()), 0);
      chk("final_syn_valid", 32'(syn_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
